// File: rtl/btb_update_queue.sv
// btb_update_queue: collects resolved-branch updates from several resolve
// ports, drops not-taken ones, and serialises taken ones in age order onto
// the BTB's single write port (one write per cycle).

// Per-port acceptance slice: decides enqueue/drop for one resolve port and
// extends the running enqueue count used to compact writes into the queue.
module btb_uq_lane #(
    parameter int ENQ_W = 2
) (
    input  logic             val,
    input  logic             taken,
    input  logic             ready,
    input  logic [ENQ_W-1:0] pfx_in,
    output logic             enq,
    output logic             drop,
    output logic [ENQ_W-1:0] pfx_out
);

    assign enq     = val && ready && taken;
    assign drop    = val && ready && !taken;
    assign pfx_out = pfx_in + ENQ_W'(enq);

endmodule

module btb_update_queue #(
    parameter int RES_PORTS     = 2,
    parameter int DEPTH         = 4,
    parameter int CPU_ADDR_BITS = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [RES_PORTS-1:0]                    res_val,
    output logic                                    res_ready,
    input  logic [RES_PORTS-1:0][CPU_ADDR_BITS-1:0] res_pc,
    input  logic [RES_PORTS-1:0][CPU_ADDR_BITS-1:0] res_targ,
    input  logic [RES_PORTS-1:0][1:0]               res_type,
    input  logic [RES_PORTS-1:0]                    res_taken,
    input  logic                                    update_hold,
    output logic                                    update_val,
    output logic [CPU_ADDR_BITS-1:0]                update_pc,
    output logic [CPU_ADDR_BITS-1:0]                update_targ,
    output logic [1:0]                              update_type,
    output logic                                    update_taken,
    output logic [$clog2(DEPTH+1)-1:0]              q_count,
    output logic [15:0]                             drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENQ_W = $clog2(RES_PORTS+1);

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_ADDR_BITS-1:0] targ;
        logic [1:0]               typ;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     count;

    logic [RES_PORTS-1:0] enq, drop;
    logic [ENQ_W-1:0]     pfx [RES_PORTS+1];
    logic [PTR_W-1:0]     waddr [RES_PORTS];
    logic [ENQ_W-1:0]     enq_num, drop_num;
    logic                 deq;
    logic [16:0]          drop_sum;

    // Ready looks only at registered occupancy, so a same-cycle drain never
    // feeds back into the resolve-side handshake.
    assign res_ready = (32'(count) + RES_PORTS) <= DEPTH;

    // Lower port index is older; the prefix chain gives each enqueueing port
    // its slot offset from tail so not-taken ports leave no holes.
    assign pfx[0] = '0;
    generate
        for (genvar i = 0; i < RES_PORTS; i++) begin : g_lane
            btb_uq_lane #(.ENQ_W(ENQ_W)) u_lane (
                .val     (res_val[i]),
                .taken   (res_taken[i]),
                .ready   (res_ready),
                .pfx_in  (pfx[i]),
                .enq     (enq[i]),
                .drop    (drop[i]),
                .pfx_out (pfx[i+1])
            );
            assign waddr[i] = tail + PTR_W'(pfx[i]);
        end
    endgenerate

    assign enq_num = pfx[RES_PORTS];

    // Number of not-taken resolutions filtered this cycle.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < RES_PORTS; i++)
            drop_num = drop_num + ENQ_W'(drop[i]);
    end

    // One extra bit catches a multi-port increment crossing the saturation point.
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_num);

    // Drain is gated combinationally by hold; data shows head regardless.
    assign deq          = (count != '0) && !update_hold;
    assign update_val   = deq;
    assign update_taken = deq;
    assign update_pc    = mem[head].pc;
    assign update_targ  = mem[head].targ;
    assign update_type  = mem[head].typ;
    assign q_count      = count;

    // Pointer, occupancy and drop-counter state; reset discards queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            head     <= head + PTR_W'(deq);
            tail     <= tail + PTR_W'(enq_num);
            count    <= count + CNT_W'(enq_num) - CNT_W'(deq);
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Entry storage write: compacted slots starting at tail, not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RES_PORTS; i++) begin
            if (enq[i])
                mem[waddr[i]] <= '{pc: res_pc[i], targ: res_targ[i], typ: res_type[i]};
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: stimulus pushes expected drains,
// a negedge monitor pops and compares whenever update_val is seen.
module tb_btb_update_queue;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        res_val;
    logic              res_ready;
    logic [1:0][31:0]  res_pc;
    logic [1:0][31:0]  res_targ;
    logic [1:0][1:0]   res_type;
    logic [1:0]        res_taken;
    logic              update_hold;
    logic              update_val;
    logic [31:0]       update_pc;
    logic [31:0]       update_targ;
    logic [1:0]        update_type;
    logic              update_taken;
    logic [2:0]        q_count;
    logic [15:0]       drop_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] targ;
        logic [1:0]  typ;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_drop = 0;

    btb_update_queue #(.RES_PORTS(2), .DEPTH(4), .CPU_ADDR_BITS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .res_val      (res_val),
        .res_ready    (res_ready),
        .res_pc       (res_pc),
        .res_targ     (res_targ),
        .res_type     (res_type),
        .res_taken    (res_taken),
        .update_hold  (update_hold),
        .update_val   (update_val),
        .update_pc    (update_pc),
        .update_targ  (update_targ),
        .update_type  (update_type),
        .update_taken (update_taken),
        .q_count      (q_count),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int p, input bit tk, input logic [31:0] pc,
                        input logic [31:0] tg, input logic [1:0] ty);
        res_val[p]   = 1'b1;
        res_taken[p] = tk;
        res_pc[p]    = pc;
        res_targ[p]  = tg;
        res_type[p]  = ty;
    endtask

    // Holds the request until ready (releasing hold so it can drain), then
    // records the expected outcome of the accepting edge.
    task automatic issue();
        int n = 0;
        while (res_ready !== 1'b1 && n < 50) begin
            update_hold = 1'b0;
            step();
            n++;
        end
        if (res_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready %b expected 1", res_ready);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (res_val[p]) begin
                    if (res_taken[p]) sb.push_back('{pc: res_pc[p], targ: res_targ[p], typ: res_type[p]});
                    else if (exp_drop < 65535) exp_drop++;
                end
            end
        end
        step();
        res_val = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        update_hold = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_complete_pending", sb.size(), 0);
    endtask

    // Monitor: every presented drain must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (q_count > 3'd4) chk("q_count_bound", q_count, 4);
            if (update_taken !== update_val) chk("update_taken_eq_val", update_taken, update_val);
            if (update_val === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_drain: pc %0h with empty scoreboard", update_pc);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("drain_pc",   update_pc,   e.pc);
                    chk("drain_targ", update_targ, e.targ);
                    chk("drain_type", update_type, e.typ);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; res_val = '0; res_taken = '0; res_pc = '0; res_targ = '0;
        res_type = '0; update_hold = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_update_val", update_val, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_res_ready", res_ready, 1);

        // Single taken resolution: visible next cycle, gone the cycle after
        step();
        slot(0, 1'b1, 32'h1008, 32'h2000, 2'd2);
        issue();
        @(negedge clk);
        chk("t1_update_val_c2", update_val, 1);
        chk("t1_update_taken_c2", update_taken, 1);
        step();
        @(negedge clk);
        chk("t1_update_val_c3", update_val, 0);
        chk("t1_q_count_c3", q_count, 0);

        // Mixed direction on both ports
        step();
        slot(0, 1'b0, 32'h100, 32'h900, 2'd1);
        slot(1, 1'b1, 32'h104, 32'h904, 2'd3);
        issue();
        @(negedge clk);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_update_val", update_val, 1);
        wait_drain();

        // Order and full under hold
        step();
        update_hold = 1'b1;
        slot(0, 1'b1, 32'h10, 32'h3010, 2'd0);
        slot(1, 1'b1, 32'h14, 32'h3014, 2'd1);
        issue();
        slot(0, 1'b1, 32'h18, 32'h3018, 2'd2);
        slot(1, 1'b1, 32'h1C, 32'h301C, 2'd3);
        issue();
        slot(0, 1'b0, 32'h999, 32'h0, 2'd0);   // presented while full: must be ignored
        @(negedge clk);
        chk("t3_full_q_count", q_count, 4);
        chk("t3_full_res_ready", res_ready, 0);
        chk("t3_hold_update_val", update_val, 0);
        step();
        res_val = '0;
        @(negedge clk);
        chk("t3_drop_ignored_when_full", drop_cnt, 1);
        step();
        update_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_drain_q_count", q_count, 32'(4 - k));
            chk("t3_drain_res_ready", res_ready, (4 - k) <= 2 ? 1 : 0);
            chk("t3_drain_val", update_val, 1);
            step();
        end
        chk("t3_sb_empty", sb.size(), 0);

        // Wrap-around with random hold
        for (int k = 0; k < 10; k++) begin
            update_hold = 1'($urandom_range(0, 1));
            slot(0, 1'b1, 32'h4000 + 32'(k * 4), 32'h8000 + 32'(k * 16), 2'(k));
            issue();
        end
        wait_drain();

        // Reset mid-operation with three entries pending
        step();
        update_hold = 1'b1;
        slot(0, 1'b1, 32'h50, 32'h150, 2'd1);
        slot(1, 1'b1, 32'h54, 32'h154, 2'd2);
        issue();
        slot(0, 1'b1, 32'h58, 32'h158, 2'd3);
        issue();
        @(negedge clk);
        chk("t5_q_count_before", q_count, 3);
        step();
        rst = 1'b1;
        update_hold = 1'b0;
        sb.delete();
        exp_drop = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_update_val", update_val, 0);
        chk("t5_q_count", q_count, 0);
        chk("t5_drop_cnt", drop_cnt, 0);
        chk("t5_res_ready", res_ready, 1);

        // Saturation: two drops per cycle for 32770 cycles = 65540 drops
        step();
        slot(0, 1'b0, 32'h700, 32'h0, 2'd0);
        slot(1, 1'b0, 32'h704, 32'h0, 2'd0);
        repeat (32767) step();
        @(negedge clk);
        chk("t6_drop_cnt_pre", drop_cnt, 32'hFFFE);
        step();
        @(negedge clk);
        chk("t6_drop_cnt_sat", drop_cnt, 32'hFFFF);
        repeat (2) step();
        res_val = '0;
        @(negedge clk);
        chk("t6_drop_cnt_hold", drop_cnt, 32'hFFFF);
        chk("t6_no_drain", update_val, 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers resolved-branch updates from the branch execution ports and serialises them onto the BTB's single synchronous write port. Sits between the branch units (resolve side) and the `btb` update interface. Filters not-taken resolutions, since the BTB only allocates on taken branches, and preserves age order across ports. Drains at most one write per cycle.

## Interface
Parameters:
- `RES_PORTS`, 2: number of branch resolve ports; lower index is older within a cycle.
- `DEPTH`, 4: queue entries; power of two, `DEPTH >= RES_PORTS`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `res_val`  in  [RES_PORTS]: resolve port valid.
- `res_ready`  out  1: shared ready for all resolve ports.
- `res_pc`  in  CPU_ADDR_BITS x RES_PORTS: branch PC.
- `res_targ`  in  CPU_ADDR_BITS x RES_PORTS: resolved target.
- `res_type`  in  2 x RES_PORTS: branch type code (passed through unchanged).
- `res_taken`  in  [RES_PORTS]: resolved direction.
- `update_hold`  in  1: when high, no entry drains this cycle.
- `update_val`  out  1: BTB write strobe.
- `update_pc`  out  CPU_ADDR_BITS: to BTB.
- `update_targ`  out  CPU_ADDR_BITS: to BTB.
- `update_type`  out  2: to BTB.
- `update_taken`  out  1: to BTB.
- `q_count`  out  $clog2(DEPTH+1): current occupancy.
- `drop_cnt`  out  16: count of not-taken resolutions filtered out.

## Operation
- Storage is a circular buffer of `{pc, targ, type}` entries, with `head` and `tail` pointers of width `$clog2(DEPTH)` that wrap modulo `DEPTH`. `count` is held separately.
- `res_ready = (DEPTH - count) >= RES_PORTS`. It is computed from the registered `count` only, and ignores any dequeue in the same cycle.
- Port i is accepted when `res_val[i] && res_ready`.
  - Accepted with `res_taken[i]=1`: the port enqueues.
  - Accepted with `res_taken[i]=0`: the entry is dropped, and `drop_cnt` increments by one per dropped port.
  - `drop_cnt` saturates at 16'hFFFF.
- Enqueueing ports are written at `tail, tail+1, …` in ascending port index. Writes are compacted, so a non-enqueueing port leaves no hole. `tail` advances by the number of enqueues.
- Drain condition is `count != 0 && !update_hold`.
  - When it holds: `update_val=1`, and `update_pc`, `update_targ`, `update_type` show the head entry combinationally.
  - `update_taken=1` whenever `update_val=1`, and 0 otherwise.
  - `head` advances at the clock edge.
- When the drain condition is false: `update_val=0`, `update_taken=0`. The data outputs still show the head entry and are don't-care.
- `count_next = count + enq_num - deq`. Overflow is impossible by the ready rule, and the bench asserts `count <= DEPTH`.
- Simultaneous enqueue and dequeue in one cycle is legal. When full the queue is still drainable, and `res_ready` rises the cycle after `count` falls to `DEPTH - RES_PORTS`.
- `res_val` with `res_ready=0` is ignored. Nothing is enqueued, and `drop_cnt` does not increment. The resolve side must hold the request.

## Timing
- Reset: `head=tail=count=0`, `drop_cnt=0`, `update_val=0`, `update_taken=0`, `res_ready=1`, `q_count=0`. Queue data is not reset.
- `rst` asserted mid-operation discards all pending entries at that edge. No `update_val` is issued in the cycle after reset.
- Latency: a resolution accepted in cycle N appears on `update_*` in cycle N+1 when the queue was empty and `update_hold=0`. The BTB writes it at the end of N+1, so a BTB read in N+2 hits.
- Throughput is 1 drain per cycle. Up to `RES_PORTS` enqueues per cycle are allowed.
- `update_hold` takes effect in the same cycle, because it gates the drain combinationally.
- `q_count` equals the registered `count`.

## Test plan
- **Single taken resolution:** reset, then port0 `val=1`, `taken=1`, `pc=0x1008`, `targ=0x2000`, `type=2` in cycle 1. Required: in cycle 2, `update_val=1`, `update_pc=0x1008`, `update_targ=0x2000`, `update_type=2`, `update_taken=1`. In cycle 3, `update_val=0` and `q_count=0`.
- **Both ports, mixed direction:** port0 `taken=0` (`pc=0x100`) and port1 `taken=1` (`pc=0x104`) in the same cycle. Required: only `0x104` is drained, and `drop_cnt=1`.
- **Order and full:** with `update_hold=1`, enqueue two taken branches per cycle for 2 cycles (`pc` `0x10, 0x14, 0x18, 0x1C`). Required: `q_count=4` and `res_ready=0`. Then release hold. Required: drains occur in the order `0x10, 0x14, 0x18, 0x1C` on 4 consecutive cycles. `res_ready` returns to 1 once `q_count=2`.
- **Wrap-around:** stream 10 taken resolutions with random `update_hold`. Required: the drained sequence equals the accepted sequence, and pointers wrap past `DEPTH-1` correctly.
- **Reset mid-operation:** with 3 entries queued, assert `rst` for one cycle. Required: the next cycle shows `update_val=0`, `q_count=0`, `drop_cnt=0`, `res_ready=1`.
- **Saturation:** force 65540 not-taken resolutions. Required: `drop_cnt` holds at 0xFFFF.
